// File: rtl/rm_event_dispatcher_pkg.sv
// Shared types and sizing for the runtime-monitor event dispatcher.
package rm_event_dispatcher_pkg;

    localparam int NrLanes   = 8;
    localparam int NrEvents  = 32;
    localparam int NrIns     = 2;
    localparam int FifoDepth = 8;
    localparam int PayloadW  = 64;

    localparam int IdW   = $clog2(NrEvents);
    localparam int LaneW = $clog2(NrLanes);
    localparam int PtrW  = $clog2(FifoDepth);
    localparam int CntW  = $clog2(FifoDepth + 1);
    localparam int InsW  = $clog2(NrIns + 1);

    typedef struct packed {
        logic [IdW-1:0]      id;
        logic [PayloadW-1:0] data;
    } rm_event_t;

endpackage

// File: rtl/rm_event_dispatcher_if.sv
// Commit-side event slots and monitor-lane handshake bundle.
interface rm_event_dispatcher_if;
    import rm_event_dispatcher_pkg::*;

    logic [NrIns-1:0]            evt_valid_i;
    logic [NrIns*IdW-1:0]        evt_id_i;
    logic [NrIns*PayloadW-1:0]   evt_data_i;
    logic                        evt_ready_o;
    logic [NrLanes-1:0]          lane_en_i;
    logic [NrLanes-1:0]          lane_valid_o;
    logic [NrLanes*IdW-1:0]      lane_id_o;
    logic [NrLanes*PayloadW-1:0] lane_data_o;
    logic [NrLanes-1:0]          lane_ready_i;

    modport master (
        output evt_valid_i, evt_id_i, evt_data_i, lane_en_i, lane_ready_i,
        input  evt_ready_o, lane_valid_o, lane_id_o, lane_data_o
    );

    modport slave (
        input  evt_valid_i, evt_id_i, evt_data_i, lane_en_i, lane_ready_i,
        output evt_ready_o, lane_valid_o, lane_id_o, lane_data_o
    );

endinterface

// File: rtl/rm_event_dispatcher_fifo.sv
// Multi-push / single-pop event buffer. Pushed slots are packed into
// consecutive entries in slot order, so gaps in push_mask leave no holes.
module rm_event_dispatcher_fifo
    import rm_event_dispatcher_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic [NrIns-1:0] push_mask,
    input  rm_event_t        push_evt [NrIns],
    input  logic             pop,
    output rm_event_t        head,
    output logic [CntW-1:0]  count,
    output logic             empty
);

    rm_event_t       mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] widx [NrIns];
    logic [InsW-1:0] n_push;

    // Each pushed slot lands at wr_ptr plus the number of pushed slots below it.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NrIns; i++) begin
            widx[i] = wr_ptr + PtrW'(n_push);
            if (push_mask[i]) n_push = n_push + InsW'(1);
        end
    end

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk_i) begin
        if (!flush) begin
            for (int i = 0; i < NrIns; i++) begin
                if (push_mask[i]) mem[widx[i]] <= push_evt[i];
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PtrW'(n_push);
            rd_ptr <= rd_ptr + PtrW'(pop);
            count  <= count + CntW'(n_push) - CntW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/rm_event_dispatcher.sv
// Runtime-monitor front end: filters commit events by ID mask, buffers
// them, and hands them one per cycle to monitor lanes in round-robin order.
module rm_event_dispatcher
    import rm_event_dispatcher_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [NrEvents-1:0] evt_mask_i,
    rm_event_dispatcher_if.slave bus,
    output logic [31:0]         filt_cnt_o
);

    logic [NrIns-1:0]   push_mask;
    rm_event_t          push_evt [NrIns];
    logic [InsW-1:0]    n_drop;
    logic [IdW-1:0]     slot_id;
    logic               accept;
    rm_event_t          head;
    logic [CntW-1:0]    count;
    logic               empty;
    logic [NrLanes-1:0] eligible;
    logic [LaneW-1:0]   grant;
    logic [LaneW-1:0]   probe;
    logic               found;
    logic               do_pop;
    logic [LaneW-1:0]   rr_ptr;
    logic [NrLanes-1:0] lane_vld_p1;
    rm_event_t          lane_evt_p1 [NrLanes];

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [InsW-1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Space for a full slot group is judged on the registered count only.
    assign bus.evt_ready_o = ((CntW'(FifoDepth) - count) >= CntW'(NrIns)) && !flush_i;
    assign accept          = bus.evt_ready_o && (|bus.evt_valid_i);

    // Split accepted slots into monitored pushes and masked-off drops.
    always_comb begin
        push_mask = '0;
        n_drop    = '0;
        slot_id   = '0;
        for (int i = 0; i < NrIns; i++) begin
            slot_id          = bus.evt_id_i[i*IdW +: IdW];
            push_evt[i].id   = slot_id;
            push_evt[i].data = bus.evt_data_i[i*PayloadW +: PayloadW];
            if (accept && bus.evt_valid_i[i]) begin
                if (evt_mask_i[slot_id]) push_mask[i] = 1'b1;
                else                     n_drop = n_drop + InsW'(1);
            end
        end
    end

    rm_event_dispatcher_fifo u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (flush_i),
        .push_mask (push_mask),
        .push_evt  (push_evt),
        .pop       (do_pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    // Cyclic search for the first free, enabled lane starting at rr_ptr.
    always_comb begin
        eligible = bus.lane_en_i & (~lane_vld_p1 | bus.lane_ready_i);
        grant    = '0;
        probe    = '0;
        found    = 1'b0;
        for (int k = 0; k < NrLanes; k++) begin
            probe = rr_ptr + LaneW'(k);
            if (!found && eligible[probe]) begin
                found = 1'b1;
                grant = probe;
            end
        end
        do_pop = found && !empty && !flush_i;
    end

    // Round-robin pointer advances past the lane just served.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       rr_ptr <= '0;
        else if (do_pop) rr_ptr <= grant + LaneW'(1);
    end

    // Lane output registers: load on grant, otherwise hold until consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_vld_p1 <= '0;
            for (int l = 0; l < NrLanes; l++) lane_evt_p1[l] <= '0;
        end else begin
            for (int l = 0; l < NrLanes; l++) begin
                if (do_pop && (grant == LaneW'(l))) begin
                    lane_evt_p1[l] <= head;
                    lane_vld_p1[l] <= 1'b1;
                end else if (bus.lane_ready_i[l]) begin
                    lane_vld_p1[l] <= 1'b0;
                end
            end
        end
    end

    // Flatten lane registers onto the bus.
    always_comb begin
        bus.lane_id_o   = '0;
        bus.lane_data_o = '0;
        for (int l = 0; l < NrLanes; l++) begin
            bus.lane_id_o[l*IdW +: IdW]           = lane_evt_p1[l].id;
            bus.lane_data_o[l*PayloadW +: PayloadW] = lane_evt_p1[l].data;
        end
    end
    assign bus.lane_valid_o = lane_vld_p1;

    // Saturating tally of masked-off events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) filt_cnt_o <= '0;
        else       filt_cnt_o <= sat_add32(filt_cnt_o, n_drop);
    end

endmodule

// File: tb/tb_rm_event_dispatcher.sv
// Directed and randomized bench for rm_event_dispatcher with a queue-based model.
module tb_rm_event_dispatcher;
    import rm_event_dispatcher_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] mask;
    logic [31:0] filt;

    rm_event_dispatcher_if bus_if ();

    rm_event_dispatcher dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .evt_mask_i (mask),
        .bus        (bus_if.slave),
        .filt_cnt_o (filt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: event queue, lane holding registers, round-robin pointer.
    rm_event_t   mq[$];
    bit          m_lv   [8];
    logic [4:0]  m_lid  [8];
    logic [63:0] m_ldat [8];
    int          m_rr;
    longint      m_fc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int l = 0; l < 8; l++) begin
            m_lv[l] = 0; m_lid[l] = '0; m_ldat[l] = '0;
        end
        m_rr = 0;
        m_fc = 0;
    endtask

    function automatic bit model_ready();
        return ((8 - mq.size()) >= 2) && !flush;
    endfunction

    task automatic model_check();
        logic [7:0] lv;
        for (int l = 0; l < 8; l++) lv[l] = m_lv[l];
        chk("evt_ready", 64'(bus_if.evt_ready_o), 64'(model_ready()));
        chk("lane_valid", 64'(bus_if.lane_valid_o), 64'(lv));
        chk("filt_cnt", 64'(filt), 64'(m_fc));
        for (int l = 0; l < 8; l++) begin
            if (m_lv[l]) begin
                chk($sformatf("lane%0d_id", l), 64'(bus_if.lane_id_o[l*5 +: 5]), 64'(m_lid[l]));
                chk($sformatf("lane%0d_data", l), bus_if.lane_data_o[l*64 +: 64], m_ldat[l]);
            end
        end
    endtask

    task automatic model_update();
        bit        rdy;
        int        g;
        int        l;
        rm_event_t e;
        logic [4:0] id;
        rdy = model_ready();
        g = -1;
        if (!flush && mq.size() > 0) begin
            for (int k = 0; k < 8; k++) begin
                l = (m_rr + k) % 8;
                if (bus_if.lane_en_i[l] && (!m_lv[l] || bus_if.lane_ready_i[l])) begin
                    g = l;
                    break;
                end
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (j == g) begin
                e = mq.pop_front();
                m_lv[j] = 1; m_lid[j] = e.id; m_ldat[j] = e.data;
            end else if (bus_if.lane_ready_i[j]) begin
                m_lv[j] = 0;
            end
        end
        if (g >= 0) m_rr = (g + 1) % 8;
        if (flush) begin
            mq.delete();
        end else if (rdy && (|bus_if.evt_valid_i)) begin
            for (int i = 0; i < 2; i++) begin
                if (bus_if.evt_valid_i[i]) begin
                    id = bus_if.evt_id_i[i*5 +: 5];
                    if (mask[id]) begin
                        e.id = id;
                        e.data = bus_if.evt_data_i[i*64 +: 64];
                        mq.push_back(e);
                    end else begin
                        m_fc = (m_fc >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_fc + 1;
                    end
                end
            end
        end
    endtask

    // One clock: settle, compare against model, advance model, cross the edge.
    task automatic cycle();
        #1;
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] v, input logic [4:0] i0, input logic [4:0] i1);
        bus_if.evt_valid_i = v;
        bus_if.evt_id_i    = {i1, i0};
        bus_if.evt_data_i  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        mask  = '1;
        bus_if.lane_en_i    = '1;
        bus_if.lane_ready_i = '1;
        offer(2'b00, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        #1;
        chk("rst_evt_ready", 64'(bus_if.evt_ready_o), 64'd1);
        chk("rst_lane_valid", 64'(bus_if.lane_valid_o), 64'h00);
        chk("rst_filt_cnt", 64'(filt), 64'd0);

        // Two monitored events go to lane0 then lane1
        offer(2'b11, 5'd3, 5'd7);
        cycle();
        offer(2'b00, 5'd0, 5'd0);
        cycle();
        chk("rr_lane_valid_a", 64'(bus_if.lane_valid_o), 64'h01);
        chk("rr_lane0_id", 64'(bus_if.lane_id_o[0 +: 5]), 64'd3);
        cycle();
        chk("rr_lane_valid_b", 64'(bus_if.lane_valid_o), 64'h02);
        chk("rr_lane1_id", 64'(bus_if.lane_id_o[5 +: 5]), 64'd7);
        cycle();

        // Masked ID 5 is dropped and counted; ID 9 goes to lane2
        mask[5] = 1'b0;
        offer(2'b11, 5'd5, 5'd9);
        cycle();
        offer(2'b00, 5'd0, 5'd0);
        cycle();
        chk("filt_one", 64'(filt), 64'd1);
        chk("mask_lane_valid", 64'(bus_if.lane_valid_o), 64'h04);
        chk("mask_lane2_id", 64'(bus_if.lane_id_o[10 +: 5]), 64'd9);
        cycle();
        mask = '1;

        // All lanes disabled: buffer fills and back-pressures
        bus_if.lane_en_i = 8'h00;
        for (int n = 0; n < 4; n++) begin
            offer(2'b11, 5'($urandom), 5'($urandom));
            cycle();
        end
        #1;
        chk("full_not_ready", 64'(bus_if.evt_ready_o), 64'd0);
        offer(2'b11, 5'($urandom), 5'($urandom));
        cycle();
        bus_if.lane_en_i = 8'h04;
        for (int n = 0; n < 12; n++) begin
            offer(2'b11, 5'($urandom), 5'($urandom));
            cycle();
        end
        offer(2'b00, 5'd0, 5'd0);
        repeat (8) cycle();

        // Lane3 holds its event while its ready is low
        bus_if.lane_en_i    = 8'hFF;
        bus_if.lane_ready_i = 8'hF7;
        for (int n = 0; n < 10; n++) begin
            offer(2'($urandom), 5'($urandom), 5'($urandom));
            cycle();
        end
        offer(2'b00, 5'd0, 5'd0);
        repeat (4) cycle();
        bus_if.lane_ready_i = 8'hFF;
        repeat (6) cycle();

        // Flush with occupied lanes and five buffered events
        bus_if.lane_ready_i = 8'h00;
        offer(2'b11, 5'd1, 5'd2);
        cycle();
        offer(2'b00, 5'd0, 5'd0);
        repeat (3) cycle();
        bus_if.lane_en_i = 8'h00;
        offer(2'b11, 5'd10, 5'd11);
        cycle();
        offer(2'b11, 5'd12, 5'd13);
        cycle();
        offer(2'b01, 5'd14, 5'd0);
        cycle();
        offer(2'b00, 5'd0, 5'd0);
        bus_if.lane_en_i = 8'hFF;
        bus_if.lane_ready_i = 8'h00;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_ready_back", 64'(bus_if.evt_ready_o), 64'd1);
        repeat (2) cycle();
        bus_if.lane_ready_i = 8'hFF;
        repeat (3) cycle();

        // Randomized traffic, with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            bus_if.lane_en_i    = 8'($urandom);
            bus_if.lane_ready_i = 8'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            offer(2'($urandom), 5'($urandom), 5'($urandom));
            cycle();
            if (n == 200) begin
                #2 rst = 1'b1;
                #1;
                chk("async_rst_lane_valid", 64'(bus_if.lane_valid_o), 64'h00);
                chk("async_rst_filt", 64'(filt), 64'd0);
                model_reset();
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
